seg_disp_ctrl: RTL and testbench

//  Refresh/commit controller directly upstream of the 8-digit 7-seg display stage.

---
 rtl/seg_disp_ctrl_if.sv | 24 ++
 rtl/seg_disp_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_seg_disp_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_disp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_disp_ctrl_if
// Purpose  : Host write bus into the seg_disp_ctrl shadow registers.
// Revision : 1.0  initial release
// ============================================================================
interface seg_disp_ctrl_if;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data
  );
endinterface
`default_nettype wire

// File: rtl/seg_disp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_disp_ctrl
// Purpose  : Shadow/commit refresh controller feeding the 8-digit 7-seg serializer.
// Revision : 1.0  initial release
// ============================================================================
module seg_disp_ctrl #(
  parameter int unsigned SHIFT_CYCLES   = 140,
  parameter int unsigned REFRESH_CYCLES = 1_000_000,
  parameter int unsigned FLASH_CYCLES   = 25_000_000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  seg_disp_ctrl_if.slave   host,
  input  wire logic        force_ref,
  output logic             Start,
  output logic [31:0]      Hexs,
  output logic [7:0]       point,
  output logic [7:0]       LES,
  output logic             Tex,
  output logic             flash,
  output logic             busy,
  output logic [15:0]      frames
);

  localparam int unsigned HOLD_W  = (SHIFT_CYCLES   > 1) ? $clog2(SHIFT_CYCLES)   : 1;
  localparam int unsigned REF_W   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned FLASH_W = (FLASH_CYCLES   > 1) ? $clog2(FLASH_CYCLES)   : 1;

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(SHIFT_CYCLES - 1);
  localparam logic [REF_W-1:0]   REF_LAST   = REF_W'(REFRESH_CYCLES - 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_CYCLES - 1);

  localparam logic [1:0] ADDR_HEXS  = 2'd0;
  localparam logic [1:0] ADDR_POINT = 2'd1;
  localparam logic [1:0] ADDR_LES   = 2'd2;
  localparam logic [1:0] ADDR_TEX   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_START = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t              r_state;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [REF_W-1:0]    r_ref_cnt;
  logic [FLASH_W-1:0]  r_flash_cnt;

  logic [31:0]         r_hexs_sh;
  logic [7:0]          r_point_sh;
  logic [7:0]          r_les_sh;
  logic                r_tex_sh;
  logic                r_flash_sh;
  logic                r_dirty;
  logic                r_ref_req;

  logic                w_ref_wrap;
  logic                w_flash_wrap;
  logic                w_trigger;
  logic                w_commit;

  assign w_ref_wrap   = (r_ref_cnt == REF_LAST);
  assign w_flash_wrap = (r_flash_cnt == FLASH_LAST);
  assign w_trigger    = r_dirty | r_ref_req | force_ref;
  assign w_commit     = (r_state == S_LOAD);

  // Free-running timers; they never pause for the frame FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ref_cnt   <= '0;
      r_flash_cnt <= '0;
    end else begin
      r_ref_cnt   <= w_ref_wrap   ? '0 : r_ref_cnt + REF_W'(1);
      r_flash_cnt <= w_flash_wrap ? '0 : r_flash_cnt + FLASH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hexs_sh  <= '0;
      r_point_sh <= '0;
      r_les_sh   <= '0;
      r_tex_sh   <= 1'b0;
      r_flash_sh <= 1'b0;
    end else begin
      if (host.wr_en) begin
        case (host.wr_addr)
          ADDR_HEXS:  r_hexs_sh  <= host.wr_data;
          ADDR_POINT: r_point_sh <= host.wr_data[7:0];
          ADDR_LES:   r_les_sh   <= host.wr_data[7:0];
          ADDR_TEX:   r_tex_sh   <= host.wr_data[0];
        endcase
      end
      if (w_flash_wrap) begin
        r_flash_sh <= ~r_flash_sh;
      end
    end
  end

  // A new request on the commit edge must survive the clear, so set has priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dirty   <= 1'b1;
      r_ref_req <= 1'b0;
    end else begin
      if (host.wr_en || w_flash_wrap) begin
        r_dirty <= 1'b1;
      end else if (w_commit) begin
        r_dirty <= 1'b0;
      end
      if (w_ref_wrap) begin
        r_ref_req <= 1'b1;
      end else if (w_commit) begin
        r_ref_req <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
      Start      <= 1'b0;
      busy       <= 1'b0;
      Hexs       <= '0;
      point      <= '0;
      LES        <= '0;
      Tex        <= 1'b0;
      flash      <= 1'b0;
      frames     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          Start <= 1'b0;
          if (w_trigger) begin
            r_state <= S_LOAD;
            busy    <= 1'b1;
          end
        end
        S_LOAD: begin
          // Display inputs only ever change here, just before Start.
          r_state <= S_START;
          Start   <= 1'b1;
          busy    <= 1'b1;
          Hexs    <= r_hexs_sh;
          point   <= r_point_sh;
          LES     <= r_les_sh;
          Tex     <= r_tex_sh;
          flash   <= r_flash_sh;
          frames  <= frames + 16'd1;
        end
        S_START: begin
          r_state    <= S_HOLD;
          r_hold_cnt <= '0;
          Start      <= 1'b0;
          busy       <= 1'b1;
        end
        S_HOLD: begin
          Start <= 1'b0;
          if (r_hold_cnt == HOLD_LAST) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            busy       <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          Start   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_disp_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for seg_disp_ctrl: directed frame-timing scenarios plus a randomized run
// compared every cycle against a frame-timeline reference model.
module tb_seg_disp_ctrl;

  localparam int unsigned SHIFT     = 10;
  localparam int unsigned REFP      = 60;
  localparam int unsigned FLASHP    = 200;
  localparam int unsigned FRAME_LEN = SHIFT + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        force_ref;
  logic        Start;
  logic [31:0] Hexs;
  logic [7:0]  point;
  logic [7:0]  LES;
  logic        Tex;
  logic        flash;
  logic        busy;
  logic [15:0] frames;

  int checks   = 0;
  int failures = 0;

  seg_disp_ctrl_if host ();

  seg_disp_ctrl #(
    .SHIFT_CYCLES  (SHIFT),
    .REFRESH_CYCLES(REFP),
    .FLASH_CYCLES  (FLASHP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .host     (host),
    .force_ref(force_ref),
    .Start    (Start),
    .Hexs     (Hexs),
    .point    (point),
    .LES      (LES),
    .Tex      (Tex),
    .flash    (flash),
    .busy     (busy),
    .frames   (frames)
  );

  always #5 clk = ~clk;

  // Reference model: shadows/committed values as arrays indexed by host address,
  // one "something to send" flag, and the position inside the busy window.
  logic [31:0] m_sh  [4];
  logic [31:0] m_out [4];
  logic        m_fsh;
  logic        m_fout;
  logic        m_pend;
  int unsigned m_pos;
  int unsigned m_age;
  logic [15:0] m_frames;

  task automatic model_reset();
    for (int a = 0; a < 4; a++) begin
      m_sh[a]  = '0;
      m_out[a] = '0;
    end
    m_fsh    = 1'b0;
    m_fout   = 1'b0;
    m_pend   = 1'b1;
    m_pos    = 0;
    m_age    = 0;
    m_frames = '0;
  endtask

  task automatic model_step();
    int unsigned nxt;
    if (m_pos == 0)              nxt = (m_pend || force_ref) ? 1 : 0;
    else if (m_pos == FRAME_LEN) nxt = 0;
    else                         nxt = m_pos + 1;
    if (m_pos == 1) begin
      for (int a = 0; a < 4; a++) m_out[a] = m_sh[a];
      m_fout   = m_fsh;
      m_frames = m_frames + 16'd1;
      m_pend   = 1'b0;
    end
    if (host.wr_en) begin
      case (host.wr_addr)
        2'd0: m_sh[0] = host.wr_data;
        2'd1: m_sh[1] = {24'd0, host.wr_data[7:0]};
        2'd2: m_sh[2] = {24'd0, host.wr_data[7:0]};
        2'd3: m_sh[3] = {31'd0, host.wr_data[0]};
      endcase
      m_pend = 1'b1;
    end
    if ((m_age % FLASHP) == FLASHP - 1) begin
      m_fsh  = ~m_fsh;
      m_pend = 1'b1;
    end
    if ((m_age % REFP) == REFP - 1) m_pend = 1'b1;
    m_pos = nxt;
    m_age++;
  endtask

  function automatic logic [67:0] model_vec();
    return {(m_pos == 2), (m_pos != 0), m_out[0], m_out[1][7:0], m_out[2][7:0],
            m_out[3][0], m_fout, m_frames};
  endfunction

  function automatic logic [67:0] dut_vec();
    return {Start, busy, Hexs, point, LES, Tex, flash, frames};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    host.wr_en   = 1'b1;
    host.wr_addr = a;
    host.wr_data = d;
    tick();
    host.wr_en   = 1'b0;
  endtask

  task automatic wait_start(input int unsigned limit, output int unsigned n);
    n = 0;
    for (int unsigned i = 1; i <= limit; i++) begin
      tick();
      if (Start === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    rst         = 1'b0;
    host.wr_en  = 1'b0;
    force_ref   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    int unsigned busy_cnt = 0;
    int unsigned start_at = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_vec() !== 68'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", dut_vec());
    end
    rst = 1'b1;
    model_reset();
    for (int unsigned i = 1; i <= 20; i++) begin
      tick();
      if (busy === 1'b1) busy_cnt++;
      if (Start === 1'b1 && start_at == 0) start_at = i;
    end
    checks++;
    if (start_at < 1 || start_at > 3) begin
      failures++;
      $display("FAIL first_start: got cycle %0d expected 1..3", start_at);
    end
    checks++;
    if (busy_cnt != FRAME_LEN) begin
      failures++;
      $display("FAIL first_busy_len: got %0d expected %0d", busy_cnt, FRAME_LEN);
    end
    checks++;
    if (Hexs !== 32'd0 || frames !== 16'd1) begin
      failures++;
      $display("FAIL first_frame: got Hexs=%h frames=%0d expected 0/1", Hexs, frames);
    end
  endtask

  task automatic test_write_latency();
    int unsigned n;
    int unsigned bad = 0;
    do_write(2'd0, 32'h1234_ABCD);
    checks++;
    if (Start !== 1'b0) begin
      failures++;
      $display("FAIL early_start: got %b expected 0", Start);
    end
    wait_start(5, n);
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL write_latency: got %0d expected 2 cycles after write edge", n);
    end
    checks++;
    if (Hexs !== 32'h1234_ABCD) begin
      failures++;
      $display("FAIL hexs_at_start: got %h expected 1234abcd", Hexs);
    end
    for (int unsigned i = 0; i < SHIFT; i++) begin
      tick();
      if (Hexs !== 32'h1234_ABCD || Start !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_stable: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_write_during_hold();
    int unsigned n;
    int unsigned bad = 0;
    for (int i = 0; i < 20 && busy === 1'b1; i++) tick();
    force_ref = 1'b1;
    tick();
    force_ref = 1'b0;
    wait_start(5, n);
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL force_ref_start: got %0d expected 1", n);
    end
    repeat (3) tick();
    do_write(2'd1, 32'h0000_00A5);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy !== 1'b1) break;
      if (point !== 8'h00) bad++;
    end
    checks++;
    if (bad != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL point_during_hold: got %0d bad, busy=%b expected 0/0", bad, busy);
    end
    wait_start(5, n);
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL deferred_start: got %0d expected 2", n);
    end
    checks++;
    if (point !== 8'hA5) begin
      failures++;
      $display("FAIL deferred_point: got %h expected a5", point);
    end
  endtask

  task automatic test_refresh();
    int unsigned q[$];
    int unsigned bad = 0;
    apply_reset();
    for (int unsigned i = 1; i <= 190; i++) begin
      tick();
      if (Start === 1'b1) q.push_back(i);
      if (Hexs !== 32'd0) bad++;
    end
    checks++;
    if (q.size() != 4 || bad != 0) begin
      failures++;
      $display("FAIL refresh_count: got %0d starts, %0d hexs changes expected 4/0", q.size(), bad);
    end else begin
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (q[k] - q[k-1] != REFP) begin
          failures++;
          $display("FAIL refresh_period: got %0d expected %0d", q[k] - q[k-1], REFP);
        end
      end
    end
  endtask

  task automatic test_flash();
    int unsigned toggles = 0;
    int unsigned bad = 0;
    logic prev;
    apply_reset();
    prev = flash;
    for (int i = 0; i < 420; i++) begin
      tick();
      if (flash !== prev) begin
        toggles++;
        if (Start !== 1'b1) bad++;
      end
      prev = flash;
    end
    checks++;
    if (toggles != 2) begin
      failures++;
      $display("FAIL flash_toggles: got %0d expected 2", toggles);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL flash_edge: got %0d toggles outside Start expected 0", bad);
    end
  endtask

  task automatic test_reset_midframe();
    int unsigned n;
    apply_reset();
    repeat (13) tick();
    do_write(2'd0, 32'hDEAD_BEEF);
    do_write(2'd2, 32'h0000_003C);
    wait_start(5, n);
    repeat (6) tick();
    checks++;
    if (Hexs !== 32'hDEAD_BEEF || LES !== 8'h3C || busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_frame: got Hexs=%h LES=%h busy=%b expected deadbeef/3c/1",
               Hexs, LES, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 68'd0) begin
      failures++;
      $display("FAIL async_reset: got %h expected 0", dut_vec());
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_start(3, n);
    checks++;
    if (n == 0) begin
      failures++;
      $display("FAIL restart_after_reset: got no Start expected within 3");
    end
    checks++;
    if (Hexs !== 32'd0 || LES !== 8'd0 || frames !== 16'd1) begin
      failures++;
      $display("FAIL restart_values: got Hexs=%h LES=%h frames=%0d expected 0/0/1",
               Hexs, LES, frames);
    end
  endtask

  task automatic test_load_edge_write();
    int unsigned n;
    apply_reset();
    repeat (13) tick();
    do_write(2'd0, 32'h1111_1111);
    tick();
    do_write(2'd0, 32'h2222_2222);
    checks++;
    if (Start !== 1'b1 || Hexs !== 32'h1111_1111) begin
      failures++;
      $display("FAIL load_edge_old: got Start=%b Hexs=%h expected 1/11111111", Start, Hexs);
    end
    wait_start(30, n);
    checks++;
    if (n != SHIFT + 3) begin
      failures++;
      $display("FAIL back_to_back: got %0d expected %0d", n, SHIFT + 3);
    end
    checks++;
    if (Hexs !== 32'h2222_2222) begin
      failures++;
      $display("FAIL load_edge_new: got %h expected 22222222", Hexs);
    end
  endtask

  task automatic test_random();
    int prints = 0;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      host.wr_en   = ($urandom_range(0, 3) == 0);
      host.wr_addr = 2'($urandom_range(0, 3));
      host.wr_data = $urandom;
      force_ref    = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 999) == 0) begin
        apply_reset();
      end else begin
        tick();
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        if (prints < 20) begin
          prints++;
          $display("FAIL random_cycle_%0d: got %h expected %h", i, dut_vec(), model_vec());
        end
      end
    end
    host.wr_en = 1'b0;
    force_ref  = 1'b0;
  endtask

  initial begin
    rst          = 1'b0;
    force_ref    = 1'b0;
    host.wr_en   = 1'b0;
    host.wr_addr = 2'd0;
    host.wr_data = 32'd0;
    model_reset();
    test_reset();
    test_write_latency();
    test_write_during_hold();
    test_refresh();
    test_flash();
    test_reset_midframe();
    test_load_edge_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
